// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding and frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS             = 8;
  localparam int FRAME_BITS            = 10;
  localparam int DEFAULT_TICKS_PER_BIT = 108;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART shifter.
// Pushes while full and pops while empty are dropped.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr;
  logic [AW-1:0]        r_rd;
  logic [CW-1:0]        r_count;
  logic                 w_push;
  logic                 w_pop;

  assign full   = (r_count == CW'(FIFO_DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries behind r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter paced by rising edges of a divided-clock level.
// Frames follow one another with no idle gap while the FIFO has data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clkdiv,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_BIT - 1);

  logic                 r_clkdiv_q;
  state_t               r_state;
  logic [TW-1:0]        r_tcnt;
  logic [2:0]           r_bidx;
  logic [DATA_BITS-1:0] r_sr;
  logic                 r_txd;

  logic                 w_tick;
  logic                 w_end;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_dout;

  assign w_tick   = clkdiv & ~r_clkdiv_q;
  assign w_end    = (r_tcnt == TLAST);
  assign w_pop    = w_tick & ~w_empty &
                    ((r_state == S_IDLE) | ((r_state == S_STOP) & w_end));
  assign tx_ready = ~w_full;
  assign txd      = r_txd;
  assign busy     = (r_state != S_IDLE) | ~w_empty;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (tx_valid),
    .din    (tx_data),
    .pop    (w_pop),
    .dout   (w_dout),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clkdiv_q <= 1'b0;
      r_state    <= S_IDLE;
      r_tcnt     <= '0;
      r_bidx     <= '0;
      r_sr       <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_clkdiv_q <= clkdiv;
      if (w_tick) begin
        unique case (r_state)
          S_IDLE: begin
            if (!w_empty) begin
              r_sr    <= w_dout;
              r_tcnt  <= '0;
              r_state <= S_START;
              r_txd   <= 1'b0;
            end
          end
          S_START: begin
            if (w_end) begin
              r_tcnt  <= '0;
              r_bidx  <= '0;
              r_state <= S_DATA;
              r_txd   <= r_sr[0];
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_DATA: begin
            if (w_end) begin
              r_tcnt <= '0;
              r_sr   <= r_sr >> 1;
              if (r_bidx == 3'(DATA_BITS - 1)) begin
                r_state <= S_STOP;
                r_txd   <= 1'b1;
              end else begin
                r_bidx <= r_bidx + 1'b1;
                r_txd  <= r_sr[1];
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          S_STOP: begin
            if (w_end) begin
              r_tcnt <= '0;
              // Chain straight into the next start bit when data is waiting.
              if (!w_empty) begin
                r_sr    <= w_dout;
                r_state <= S_START;
                r_txd   <= 1'b0;
              end else begin
                r_state <= S_IDLE;
                r_txd   <= 1'b1;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed/random bench for uart_tx: decodes txd against a byte-queue model.
// Bit period is 4 ticks x 4 clk = 16 clk.
module tb_uart_tx;

  typedef logic [7:0] bq_t[$];

  localparam int TPB = 4;
  localparam int BITCLK = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clkdiv = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  logic [1:0] r_div = 2'd0;
  logic       m_prev = 1'b0;
  logic       m_tick = 1'b0;
  int         cyc = 0;

  int checks = 0;
  int failures = 0;

  bq_t  exp_q;
  bq_t  qa;
  int   nacc, nacc2, lastacc, acc6, nrej, st, lat;
  logic stt;
  logic [3:0] latmask;

  uart_tx #(
    .TICKS_PER_BIT(TPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clkdiv  (clkdiv),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .txd     (txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    r_div = r_div + 2'd1;
    clkdiv = r_div[1];
  end

  always @(posedge clk) begin
    m_tick = clkdiv & ~m_prev;
    m_prev = clkdiv;
    cyc = cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Present bytes in order, each until accepted, for at most win cycles.
  task automatic drive(input bq_t b, input int win, output int na,
                       output int last, output int nr);
    int idx = 0;
    na = 0; last = 0; nr = 0;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      if (idx >= b.size()) begin
        tx_valid = 1'b0;
        break;
      end
      tx_valid = 1'b1;
      tx_data = b[idx];
      if (tx_ready) begin
        exp_q.push_back(b[idx]);
        idx++;
        na++;
        last = cyc + 1;
      end else begin
        nr++;
      end
    end
    if (tx_valid) begin
      @(posedge clk);
      #1 tx_valid = 1'b0;
    end
  endtask

  task automatic wait_fall(output bit found, output int s, output logic tk);
    int w = 0;
    found = 0; s = 0; tk = 1'b0;
    while (!found && w < 200) begin
      @(negedge clk);
      w++;
      if (txd === 1'b0) found = 1;
    end
    if (found) begin
      s = cyc;
      tk = m_tick;
    end
  endtask

  // Decode n back-to-back frames, every level held for BITCLK samples.
  task automatic check_frames(input int n, output int s, output logic tk);
    bit found;
    bit ok;
    logic [7:0] b;
    logic [9:0] fr;
    wait_fall(found, s, tk);
    if (!found) begin
      fail_now("start_bit_seen");
      return;
    end
    for (int f = 0; f < n; f++) begin
      if (exp_q.size() == 0) begin
        fail_now("model_byte_available");
        return;
      end
      b = exp_q.pop_front();
      fr = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
        ok = 1;
        for (int j = 0; j < BITCLK; j++) begin
          if (!(f == 0 && k == 0 && j == 0)) @(negedge clk);
          if (txd !== fr[k]) ok = 0;
        end
        chk($sformatf("frame%0d_byte%02h_bit%0d_level", f, b, k), ok, 1);
      end
    end
  endtask

  task automatic check_end();
    chk("busy_last_stop_clk", busy, 1);
    @(negedge clk);
    chk("busy_after_stop", busy, 0);
    chk("txd_idle", txd, 1);
  endtask

  initial begin
    latmask = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_txd", txd, 1);
    chk("idle_busy", busy, 0);

    // Single byte
    qa = {8'hA5};
    fork
      drive(qa, 50, nacc, lastacc, nrej);
      check_frames(1, st, stt);
    join
    check_end();

    // Back-to-back
    qa = {8'h00, 8'hFF, 8'h3C};
    fork
      drive(qa, 50, nacc, lastacc, nrej);
      check_frames(3, st, stt);
    join
    chk("b2b_accepted", nacc, 3);
    chk("b2b_ready_drops", nrej, 0);
    check_end();

    // Overflow, then push held against the pop from full
    qa = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    fork
      begin
        drive(qa, 20, nacc, lastacc, nrej);
        chk("ovf_accepted", nacc, 5);
        drive({qa[5]}, 400, nacc2, acc6, nrej);
        chk("full_push_accepted", nacc2, 1);
      end
      check_frames(6, st, stt);
    join
    chk("full_push_cycle_after_pop", acc6 - st, 161);
    check_end();

    // Reset in DATA bit 3
    qa = {8'hC3};
    drive(qa, 50, nacc, lastacc, nrej);
    begin
      bit found;
      wait_fall(found, st, stt);
      if (!found) fail_now("rst_frame_start");
    end
    repeat (70) @(negedge clk);
    chk("pre_rst_data_bit3", txd, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", tx_ready, 1);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    qa = {8'h81};
    fork
      drive(qa, 50, nacc, lastacc, nrej);
      check_frames(1, st, stt);
    join
    check_end();

    // One push per clkdiv phase, random payloads
    for (int p = 0; p < 4; p++) begin
      int g = 0;
      while ((cyc % 4) != p && g < 8) begin
        @(negedge clk);
        g++;
      end
      qa = {8'($urandom)};
      fork
        drive(qa, 10, nacc, lastacc, nrej);
        check_frames(1, st, stt);
      join
      lat = st - lastacc;
      chk($sformatf("phase%0d_latency_in_1_4", p),
          (lat >= 1 && lat <= 4), 1);
      chk($sformatf("phase%0d_fall_on_tick", p), stt, 1);
      if (lat >= 1 && lat <= 4) latmask[lat-1] = 1'b1;
      check_end();
    end
    chk("all_latencies_seen", latmask, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
